// File: rtl/mem_responder_pkg.sv
// Shared definitions for the serial memory responder: CPU header codes and FSM state types.
package mem_responder_pkg;

  // Header codes carried in the single header cycle of a TX message.
  localparam int unsigned TX_CMD_BITS = 2;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 2'b01;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 2'b10;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'b11;

  typedef enum logic [1:0] {DIdle, DHdr, DAddr, DData} dec_state_e;
  typedef enum logic [1:0] {AIdle, ARead, AWrite} acc_state_e;
  typedef enum logic [1:0] {RIdle, RStart, RData} rep_state_e;

  // 2'b00 and any code not listed above is a protocol error.
  function automatic logic header_valid(input logic [TX_CMD_BITS-1:0] hdr);
    return (hdr == TX_HEADER_READ_16) || (hdr == TX_HEADER_WRITE_8) ||
           (hdr == TX_HEADER_WRITE_16);
  endfunction

endpackage

// File: rtl/mem_reply_serializer.sv
// Captures one read word and sends it back on the RX lane: start cycle, then the word LSB first.
module mem_reply_serializer
  import mem_responder_pkg::*;
#(
  parameter int unsigned NSHIFT    = 2,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [NSHIFT-1:0]    rx_o,
  output logic                 idle_o
);

  localparam int unsigned PayloadCycles = DATA_BITS / NSHIFT;
  localparam int unsigned CntW = (PayloadCycles > 1) ? $clog2(PayloadCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PayloadCycles - 1);

  rep_state_e            rep_q, rep_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Reply sequencing and lane drive; rx is zero whenever no reply is in flight.
  always_comb begin
    rep_d   = rep_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rx_o    = '0;
    unique case (rep_q)
      RIdle: begin
        if (load_i) begin
          shift_d = data_i;
          rep_d   = RStart;
        end
      end
      RStart: begin
        rx_o  = NSHIFT'(1);
        cnt_d = '0;
        rep_d = RData;
      end
      RData: begin
        rx_o    = shift_q[NSHIFT-1:0];
        shift_d = shift_q >> NSHIFT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          rep_d = RIdle;
        end
      end
      default: rep_d = RIdle;
    endcase
  end

  assign idle_o = (rep_q == RIdle);

  // Reply state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q   <= RIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      rep_q   <= rep_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory end of the CPU serial bus: decodes TX commands, runs the memory access and returns
// read data as RX replies. One outstanding access and one reply at a time.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned NSHIFT    = 2,
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSHIFT-1:0]    tx_pins,
  output logic [NSHIFT-1:0]    rx_pins,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic [1:0]           mem_be,
  output logic                 mem_re,
  output logic                 mem_we,
  input  logic                 mem_ready,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy,
  output logic                 error
);

  localparam int unsigned AddrCycles    = ADDR_BITS / NSHIFT;
  localparam int unsigned PayloadCycles = DATA_BITS / NSHIFT;
  localparam int unsigned MaxCycles     = (AddrCycles > PayloadCycles) ? AddrCycles
                                                                       : PayloadCycles;
  localparam int unsigned CntW          = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned HalfBits      = DATA_BITS / 2;
  localparam logic [CntW-1:0] AddrLast  = CntW'(AddrCycles - 1);
  localparam logic [CntW-1:0] W16Last   = CntW'(PayloadCycles - 1);
  localparam logic [CntW-1:0] W8Last    = CntW'(PayloadCycles / 2 - 1);

  // Decoder state
  dec_state_e             dec_q, dec_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [TX_CMD_BITS-1:0] hdr_q, hdr_d;
  logic [ADDR_BITS-1:0]   addr_sr_q, addr_sr_d;
  logic [DATA_BITS-1:0]   data_sr_q, data_sr_d;
  logic                   armed_q, armed_d;

  // Access state
  acc_state_e             acc_q, acc_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]             mem_be_q, mem_be_d;
  logic                   error_q, error_d;

  // Decoder -> access handoff
  logic                   req_valid, req_write, hdr_err;
  logic [ADDR_BITS-1:0]   full_addr, req_addr;
  logic [DATA_BITS-1:0]   full_data, req_wdata;
  logic [HalfBits-1:0]    req_byte;
  logic [1:0]             req_be;
  logic [CntW-1:0]        data_last;

  logic                   acc_done, rd_capture, reply_load, reply_idle;

  // Fields arrive LSB first, so each cycle's slice enters at the top of the shift register;
  // the full value includes the slice on the lane this cycle.
  assign full_addr = {tx_pins, addr_sr_q[ADDR_BITS-1:NSHIFT]};
  assign full_data = {tx_pins, data_sr_q[DATA_BITS-1:NSHIFT]};
  assign data_last = (hdr_q == TX_HEADER_WRITE_8) ? W8Last : W16Last;

  // Reads end in the address phase, writes in the data phase.
  assign req_write = (hdr_q != TX_HEADER_READ_16);
  assign req_addr  = (dec_q == DAddr) ? full_addr : addr_sr_q;
  assign req_byte  = full_data[DATA_BITS-1 -: HalfBits];
  assign req_wdata = (hdr_q == TX_HEADER_WRITE_8) ? {req_byte, req_byte} : full_data;
  assign req_be    = (hdr_q == TX_HEADER_WRITE_8) ? (req_addr[0] ? 2'b10 : 2'b01) : 2'b11;

  // Decoder: next state, field shifting and end-of-message request.
  always_comb begin
    dec_d     = dec_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    armed_d   = armed_q;
    req_valid = 1'b0;
    hdr_err   = 1'b0;
    unique case (dec_q)
      DIdle: begin
        // After reset the line must be seen idle before a start bit counts.
        if (!armed_q) begin
          if (tx_pins == '0) armed_d = 1'b1;
        end else if (tx_pins[0]) begin
          dec_d = DHdr;
        end
      end
      DHdr: begin
        hdr_d = tx_pins[TX_CMD_BITS-1:0];
        cnt_d = '0;
        if (header_valid(tx_pins[TX_CMD_BITS-1:0])) begin
          dec_d = DAddr;
        end else begin
          hdr_err = 1'b1;
          dec_d   = DIdle;
        end
      end
      DAddr: begin
        addr_sr_d = full_addr;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == AddrLast) begin
          cnt_d = '0;
          if (hdr_q == TX_HEADER_READ_16) begin
            req_valid = 1'b1;
            dec_d     = DIdle;
          end else begin
            dec_d = DData;
          end
        end
      end
      DData: begin
        data_sr_d = full_data;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == data_last) begin
          req_valid = 1'b1;
          dec_d     = DIdle;
        end
      end
      default: dec_d = DIdle;
    endcase
  end

  // Decoder registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q     <= DIdle;
      cnt_q     <= '0;
      hdr_q     <= '0;
      addr_sr_q <= '0;
      data_sr_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      dec_q     <= dec_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      armed_q   <= armed_d;
    end
  end

  assign acc_done   = (acc_q != AIdle) && mem_ready;
  assign rd_capture = (acc_q == ARead) && mem_ready;
  assign reply_load = rd_capture && reply_idle;

  // Access: accept a request when idle or finishing this cycle, otherwise flag an overrun.
  always_comb begin
    acc_d       = acc_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    error_d     = error_q;
    if (acc_done) acc_d = AIdle;
    if (req_valid) begin
      if ((acc_q == AIdle) || acc_done) begin
        acc_d      = req_write ? AWrite : ARead;
        mem_addr_d = req_addr;
        mem_be_d   = req_be;
        if (req_write) mem_wdata_d = req_wdata;
      end else begin
        error_d = 1'b1;
      end
    end
    // A read that completes while the previous reply is still going out is lost.
    if (hdr_err || (rd_capture && !reply_idle)) error_d = 1'b1;
  end

  // Access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= AIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      error_q     <= error_d;
    end
  end

  mem_reply_serializer #(
    .NSHIFT    (NSHIFT),
    .DATA_BITS (DATA_BITS)
  ) u_reply (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (reply_load),
    .data_i (mem_rdata),
    .rx_o   (rx_pins),
    .idle_o (reply_idle)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_re    = (acc_q == ARead);
  assign mem_we    = (acc_q == AWrite);
  assign error     = error_q;
  assign busy      = (dec_q != DIdle) || (acc_q != AIdle) || !reply_idle;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model (pending access + queue of expected RX
// values) checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk, rst_n;
  logic [1:0]  tx_pins, rx_pins, mem_be;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, mem_ready, busy, error;

  mem_responder #(.NSHIFT(2), .ADDR_BITS(16), .DATA_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_pins   (tx_pins),
    .rx_pins   (rx_pins),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Driver-side facts about the current cycle, consumed by the model.
  bit          m_dec_busy, m_req_fire, m_hdr_bad, m_req_write;
  logic [15:0] m_req_addr, m_req_wdata;
  logic [1:0]  m_req_be;

  // Model: outstanding access and RX values still to appear (front = this cycle).
  bit          e_acc_valid, e_write, e_error;
  logic [15:0] e_addr, e_wdata;
  logic [1:0]  e_be;
  logic [1:0]  rxq[$];

  // Memory side stimulus.
  bit          manual_ready = 1'b1;
  int          ready_pct = 100;
  bit          rdata_fixed_en = 1'b0;
  logic [15:0] rdata_fixed = 16'h0;

  int          re_starts = 0, we_starts = 0;
  bit          re_prev = 1'b0, we_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit done, rbusy;
    if (!rst_n) begin
      e_acc_valid = 1'b0;
      e_error     = 1'b0;
      rxq.delete();
      return;
    end
    done  = e_acc_valid && mem_ready;
    rbusy = rxq.size() != 0;
    if (rbusy) void'(rxq.pop_front());
    if (done && !e_write) begin
      if (rbusy) e_error = 1'b1;
      else begin
        rxq.push_back(2'b01);
        for (int k = 0; k < 8; k++) rxq.push_back(mem_rdata[2*k +: 2]);
      end
    end
    if (m_req_fire) begin
      if (!e_acc_valid || done) begin
        e_acc_valid = 1'b1;
        e_write     = m_req_write;
        e_addr      = m_req_addr;
        e_wdata     = m_req_wdata;
        e_be        = m_req_be;
      end else begin
        e_error = 1'b1;
      end
    end else if (done) begin
      e_acc_valid = 1'b0;
    end
    if (m_hdr_bad) e_error = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!manual_ready) mem_ready = ($urandom_range(0, 99) < ready_pct);
    mem_rdata = rdata_fixed_en ? rdata_fixed : 16'($urandom);
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("rx_pins", 32'(rx_pins), 32'((rxq.size() != 0) ? rxq[0] : 2'b00));
      chk("mem_re", 32'(mem_re), 32'(e_acc_valid && !e_write));
      chk("mem_we", 32'(mem_we), 32'(e_acc_valid && e_write));
      if (e_acc_valid) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_be", 32'(mem_be), 32'(e_be));
        if (e_write) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      chk("error", 32'(error), 32'(e_error));
      chk("busy", 32'(busy), 32'(m_dec_busy || e_acc_valid || (rxq.size() != 0)));
    end
    if (mem_re && !re_prev) re_starts++;
    if (mem_we && !we_prev) we_starts++;
    re_prev = mem_re;
    we_prev = mem_we;
  end

  task automatic drive(input logic [1:0] v, input bit dbusy);
    @(posedge clk);
    #1;
    tx_pins    = v;
    m_dec_busy = dbusy;
    m_req_fire = 1'b0;
    m_hdr_bad  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 1'b0);
  endtask

  task automatic post_req(input logic [1:0] hdr, input logic [15:0] addr,
                          input logic [15:0] data);
    m_req_fire  = 1'b1;
    m_req_write = (hdr != TX_HEADER_READ_16);
    m_req_addr  = addr;
    if (hdr == TX_HEADER_WRITE_8) begin
      m_req_wdata = {data[7:0], data[7:0]};
      m_req_be    = addr[0] ? 2'b10 : 2'b01;
    end else begin
      m_req_wdata = data;
      m_req_be    = 2'b11;
    end
  endtask

  // Leaves the caller inside the last field cycle of the message.
  task automatic send_msg(input logic [1:0] hdr, input logic [15:0] addr,
                          input logic [15:0] data);
    int nd;
    drive({1'($urandom_range(0, 1)), 1'b1}, 1'b0);
    drive(hdr, 1'b1);
    if (hdr == 2'b00) begin
      m_hdr_bad = 1'b1;
      return;
    end
    nd = (hdr == TX_HEADER_WRITE_16) ? 8 : (hdr == TX_HEADER_WRITE_8) ? 4 : 0;
    for (int i = 0; i < 8; i++) begin
      drive(addr[2*i +: 2], 1'b1);
      if (i == 7 && nd == 0) post_req(hdr, addr, data);
    end
    for (int i = 0; i < nd; i++) begin
      drive(data[2*i +: 2], 1'b1);
      if (i == nd - 1) post_req(hdr, addr, data);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx"}, 32'(rx_pins), 32'h0);
    chk({tag, "_re"}, 32'(mem_re), 32'h0);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_be"}, 32'(mem_be), 32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
  endtask

  task automatic reset_clean();
    @(posedge clk);
    #1;
    rst_n = 1'b0; tx_pins = 2'b00;
    m_dec_busy = 1'b0; m_req_fire = 1'b0; m_hdr_bad = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
  endtask

  logic [1:0] rd_seq [8];
  int         hold_cnt;
  bit         hold_bad, rx_seen;
  logic [1:0] hdr;
  int         r;

  initial begin
    rd_seq = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};  // 16'hBEEF, LSB first
    tx_pins = 2'b00; rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
    m_dec_busy = 1'b0; m_req_fire = 1'b0; m_hdr_bad = 1'b0;
    m_req_write = 1'b0; m_req_addr = '0; m_req_wdata = '0; m_req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a read message, line busy while reset is low.
    drive(2'b01, 1'b0);
    drive(TX_HEADER_READ_16, 1'b1);
    drive(2'b10, 1'b1);
    drive(2'b11, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; m_dec_busy = 1'b0;
    for (int i = 0; i < 4; i++) drive(2'($urandom), 1'b0);
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1; tx_pins = 2'b01;
    drive(2'b01, 1'b0);
    @(negedge clk);
    chk("unarmed_start_busy", 32'(busy), 32'h0);
    idle(1);

    // Clean read with memory always ready.
    manual_ready = 1'b1; mem_ready = 1'b1;
    rdata_fixed = 16'hBEEF; rdata_fixed_en = 1'b1;
    idle(1);
    send_msg(TX_HEADER_READ_16, 16'h1234, 16'h0);
    idle(1);
    @(negedge clk);
    chk("rd_re", 32'(mem_re), 32'h1);
    chk("rd_addr", 32'(mem_addr), 32'h1234);
    chk("rd_be", 32'(mem_be), 32'h3);
    idle(1);
    @(negedge clk);
    chk("rd_re_drop", 32'(mem_re), 32'h0);
    chk("rd_start", 32'(rx_pins), 32'h1);
    for (int k = 0; k < 8; k++) begin
      idle(1);
      @(negedge clk);
      chk("rd_data", 32'(rx_pins), 32'(rd_seq[k]));
    end
    idle(1);
    @(negedge clk);
    chk("rd_end", 32'(rx_pins), 32'h0);
    idle(3);

    // Byte write to an odd address.
    send_msg(TX_HEADER_WRITE_8, 16'h0101, 16'h00A5);
    idle(1);
    @(negedge clk);
    chk("w8_we", 32'(mem_we), 32'h1);
    chk("w8_addr", 32'(mem_addr), 32'h0101);
    chk("w8_be", 32'(mem_be), 32'h2);
    chk("w8_wdata", 32'(mem_wdata), 32'hA5A5);
    rx_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      @(negedge clk);
      if (rx_pins != 2'b00) rx_seen = 1'b1;
    end
    chk("w8_no_rx", 32'(rx_seen), 32'h0);

    // Word write with the memory stalling five cycles.
    mem_ready = 1'b0;
    send_msg(TX_HEADER_WRITE_16, 16'h0040, 16'h55AA);
    hold_cnt = 0; hold_bad = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      idle(1);
      mem_ready = (c == 6);
      @(negedge clk);
      if (mem_we) begin
        hold_cnt++;
        if (mem_addr != 16'h0040 || mem_wdata != 16'h55AA || mem_be != 2'b11) hold_bad = 1'b1;
      end
    end
    chk("w16_hold_cycles", 32'(hold_cnt), 32'd6);
    chk("w16_fields_stable", 32'(hold_bad), 32'h0);
    mem_ready = 1'b1;
    idle(2);

    // Back-to-back read then word write.
    re_starts = 0; we_starts = 0;
    send_msg(TX_HEADER_READ_16, 16'hA0A0, 16'h0);
    send_msg(TX_HEADER_WRITE_16, 16'hB0B0, 16'h1357);
    idle(15);
    chk("b2b_reads", 32'(re_starts), 32'd1);
    chk("b2b_writes", 32'(we_starts), 32'd1);
    chk("b2b_error", 32'(error), 32'h0);

    // Second read arrives while the first is stalled: dropped, error sticky.
    mem_ready = 1'b0;
    re_starts = 0;
    send_msg(TX_HEADER_READ_16, 16'h2000, 16'h0);
    send_msg(TX_HEADER_READ_16, 16'h3000, 16'h0);
    idle(3);
    chk("ovr_error", 32'(error), 32'h1);
    chk("ovr_addr_first", 32'(mem_addr), 32'h2000);
    mem_ready = 1'b1;
    idle(15);
    chk("ovr_one_access", 32'(re_starts), 32'd1);
    chk("ovr_error_sticky", 32'(error), 32'h1);
    rdata_fixed_en = 1'b0;

    // Randomized traffic against the model.
    manual_ready = 1'b0;
    for (int blk = 0; blk < 4; blk++) begin
      reset_clean();
      ready_pct = (blk == 0) ? 100 : (blk == 1) ? 60 : (blk == 2) ? 25 : 85;
      for (int m = 0; m < 20; m++) begin
        r = int'($urandom_range(0, 19));
        hdr = (r == 0) ? 2'b00 : (r < 8) ? TX_HEADER_READ_16 :
              (r < 14) ? TX_HEADER_WRITE_8 : TX_HEADER_WRITE_16;
        send_msg(hdr, 16'($urandom), 16'($urandom));
        if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 12)));
      end
      idle(30);
    end

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
